// File: rtl/oq_drr_scheduler_pkg.sv
// Shared types and constant helpers for the output-queue DRR scheduler.
// State and deficit-bank opcode encodings, log2 and saturating-sum width.
package oq_drr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEF_NOP     = 2'd0,
        DEF_LOAD    = 2'd1,
        DEF_CLR_ONE = 2'd2,
        DEF_CLR_ALL = 2'd3
    } def_op_t;

    // Index width for n entries, at least one bit.
    function automatic int oq_log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // deficit + quantum needs one carry bit to detect saturation.
    function automatic int sat_sum_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/oq_drr_scheduler_deficit_bank.sv
// Per-queue deficit counter array: one indexed read, one write op per clock.
// Ports: clk, reset (async low), rd_idx/rd_data, op, wr_idx, wr_data.
module oq_drr_scheduler_deficit_bank
    import oq_drr_scheduler_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_WIDTH   = 3,
    parameter int DATA_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  def_op_t               op,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] deficit [NUM_ENTRIES];

    assign rd_data = deficit[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                deficit[i] <= '0;
            end
        end else begin
            unique case (op)
                DEF_NOP: ;
                DEF_LOAD: deficit[wr_idx] <= wr_data;
                DEF_CLR_ONE: deficit[wr_idx] <= '0;
                DEF_CLR_ALL: begin
                    for (int i = 0; i < NUM_ENTRIES; i++) begin
                        deficit[i] <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/oq_drr_scheduler.sv
// Output-queue scheduler: round robin or deficit round robin over N queues.
// Ports: queue status/len/quantum in, drr_mode, grant_vld/oq/len out, ack/done in.
module oq_drr_scheduler
    import oq_drr_scheduler_pkg::*;
#(
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int PKT_WORD_CNT_WIDTH = 8,
    parameter int QUANTUM_WIDTH      = 12,
    parameter int NUM_OQ_WIDTH       = oq_log2(NUM_OUTPUT_QUEUES),
    parameter int DEFICIT_WIDTH      = QUANTUM_WIDTH + 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_OUTPUT_QUEUES-1:0]                    q_nonempty,
    input  logic [NUM_OUTPUT_QUEUES-1:0]                    q_enable,
    input  logic [NUM_OUTPUT_QUEUES-1:0]                    out_rdy,
    input  logic [NUM_OUTPUT_QUEUES*PKT_WORD_CNT_WIDTH-1:0] head_len,
    input  logic [NUM_OUTPUT_QUEUES*QUANTUM_WIDTH-1:0]      quantum,
    input  logic                                            drr_mode,
    output logic                                            grant_vld,
    output logic [NUM_OQ_WIDTH-1:0]                         grant_oq,
    output logic [PKT_WORD_CNT_WIDTH-1:0]                   grant_len,
    input  logic                                            grant_ack,
    input  logic                                            pkt_done
);

    localparam int N  = NUM_OUTPUT_QUEUES;
    localparam int NW = NUM_OQ_WIDTH;
    localparam int PW = PKT_WORD_CNT_WIDTH;
    localparam int QW = QUANTUM_WIDTH;
    localparam int DW = DEFICIT_WIDTH;
    localparam int SW = sat_sum_width(DEFICIT_WIDTH);

    state_t         state, state_n;
    logic [NW-1:0]  ptr, ptr_n, ptr_inc;
    logic           new_visit, new_visit_n;
    logic           mode, mode_n;
    logic [NW-1:0]  grant_oq_n;
    logic [PW-1:0]  grant_len_n;

    logic [PW-1:0]  hl;
    logic [QW-1:0]  qt;
    logic           elig;
    logic [DW-1:0]  def_rd;
    logic [DW-1:0]  def_wr;
    def_op_t        def_op;
    logic [SW-1:0]  sum;
    logic [DW-1:0]  d;
    logic           fits;

    oq_drr_scheduler_deficit_bank #(
        .NUM_ENTRIES (N),
        .IDX_WIDTH   (NW),
        .DATA_WIDTH  (DW)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (ptr),
        .rd_data (def_rd),
        .op      (def_op),
        .wr_idx  (ptr),
        .wr_data (def_wr)
    );

    assign ptr_inc = (ptr == NW'(N - 1)) ? '0 : ptr + 1'b1;
    assign hl      = head_len[int'(ptr)*PW +: PW];
    assign qt      = quantum[int'(ptr)*QW +: QW];
    assign elig    = q_nonempty[ptr] & q_enable[ptr] & out_rdy[ptr];

    // Quantum is credited only on the first look of a visit.
    assign sum  = SW'(def_rd) + SW'(new_visit ? qt : '0);
    assign d    = sum[DW] ? '1 : sum[DW-1:0];
    assign fits = d >= DW'(hl);

    assign grant_vld = (state == ST_GRANT);

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        new_visit_n = new_visit;
        mode_n      = mode;
        grant_oq_n  = grant_oq;
        grant_len_n = grant_len;
        def_op      = DEF_NOP;
        def_wr      = d;
        unique case (state)
            ST_SCAN: begin
                // A mode switch spends this scan cycle resetting credit.
                if (drr_mode != mode) begin
                    mode_n      = drr_mode;
                    new_visit_n = 1'b1;
                    def_op      = DEF_CLR_ALL;
                end else if (!mode) begin
                    if (elig) begin
                        state_n     = ST_GRANT;
                        grant_oq_n  = ptr;
                        grant_len_n = hl;
                    end else begin
                        ptr_n = ptr_inc;
                    end
                end else if (!q_nonempty[ptr]) begin
                    def_op      = DEF_CLR_ONE;
                    ptr_n       = ptr_inc;
                    new_visit_n = 1'b1;
                end else if (!elig) begin
                    ptr_n       = ptr_inc;
                    new_visit_n = 1'b1;
                end else if (hl == '0) begin
                    state_n     = ST_GRANT;
                    grant_oq_n  = ptr;
                    grant_len_n = hl;
                end else if (fits) begin
                    state_n     = ST_GRANT;
                    grant_oq_n  = ptr;
                    grant_len_n = hl;
                    def_op      = DEF_LOAD;
                    def_wr      = d - DW'(hl);
                    new_visit_n = 1'b0;
                end else begin
                    def_op      = DEF_LOAD;
                    def_wr      = d;
                    ptr_n       = ptr_inc;
                    new_visit_n = 1'b1;
                end
            end
            ST_GRANT: begin
                if (grant_ack) state_n = ST_BUSY;
            end
            ST_BUSY: begin
                // DRR stays on the queue so it can spend leftover deficit.
                if (pkt_done) begin
                    state_n = ST_SCAN;
                    if (!mode) ptr_n = ptr_inc;
                end
            end
            default: state_n = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_SCAN;
            ptr       <= '0;
            new_visit <= 1'b1;
            mode      <= 1'b0;
            grant_oq  <= '0;
            grant_len <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            new_visit <= new_visit_n;
            mode      <= mode_n;
            grant_oq  <= grant_oq_n;
            grant_len <= grant_len_n;
        end
    end

endmodule

// File: tb/tb_oq_drr_scheduler.sv
// Directed bench for oq_drr_scheduler: table of grants plus corner sequences.
// Drives queue state, serves grants with ack/done, checks grant outputs and deficits.
module tb_oq_drr_scheduler;

    localparam int N  = 8;
    localparam int PW = 8;
    localparam int QW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    q_nonempty;
    logic [N-1:0]    q_enable;
    logic [N-1:0]    out_rdy;
    logic [N*PW-1:0] head_len;
    logic [N*QW-1:0] quantum;
    logic            drr_mode;
    logic            grant_vld;
    logic [2:0]      grant_oq;
    logic [PW-1:0]   grant_len;
    logic            grant_ack;
    logic            pkt_done;

    int checks   = 0;
    int failures = 0;

    oq_drr_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .q_nonempty (q_nonempty),
        .q_enable   (q_enable),
        .out_rdy    (out_rdy),
        .head_len   (head_len),
        .quantum    (quantum),
        .drr_mode   (drr_mode),
        .grant_vld  (grant_vld),
        .grant_oq   (grant_oq),
        .grant_len  (grant_len),
        .grant_ack  (grant_ack),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int setup;
        int oq;
        int len;
        int def;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int def_of(input int q);
        return int'(dut.u_bank.deficit[q]);
    endfunction

    task automatic set_q(input int q, input logic ne, input int len,
                         input int qt);
        q_nonempty[q]       = ne;
        head_len[q*PW +: PW] = len[PW-1:0];
        quantum[q*QW +: QW]  = qt[QW-1:0];
    endtask

    task automatic apply_reset(input logic drr);
        reset      = 1'b0;
        q_nonempty = '0;
        q_enable   = '1;
        out_rdy    = '1;
        head_len   = '0;
        quantum    = '0;
        drr_mode   = drr;
        grant_ack  = 1'b0;
        pkt_done   = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic take_grant(input string nm, input int oq, input int len,
                              input int def);
        for (int i = 0; i < 60 && !grant_vld; i++) step();
        chk({nm, "_vld"}, int'(grant_vld), 1);
        chk({nm, "_oq"}, int'(grant_oq), oq);
        chk({nm, "_len"}, int'(grant_len), len);
        if (def >= 0) chk({nm, "_def"}, def_of(oq), def);
    endtask

    task automatic ack_grant();
        repeat (3) step();
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
    endtask

    task automatic done_grant();
        repeat (3) step();
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 0, 10, -1};
        vecs[1] = '{0, 3, 13, -1};
        vecs[2] = '{0, 5, 15, -1};
        vecs[3] = '{0, 0, 10, -1};
        vecs[4] = '{0, 3, 13, -1};
        vecs[5] = '{0, 5, 15, -1};
        vecs[6] = '{2, 1, 6, 2};
        vecs[7] = '{0, 0, 6, 2};
        vecs[8] = '{0, 1, 6, 4};
        vecs[9] = '{0, 0, 6, 0};

        // Reset values and one-cycle decision latency.
        apply_reset(1'b0);
        reset = 1'b0;
        set_q(0, 1'b1, 10, 0);
        #1;
        chk("rst_vld", int'(grant_vld), 0);
        chk("rst_oq", int'(grant_oq), 0);
        chk("rst_len", int'(grant_len), 0);
        chk("rst_def", def_of(0), 0);
        reset = 1'b1;
        step();
        chk("lat_vld", int'(grant_vld), 1);
        chk("lat_len", int'(grant_len), 10);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].setup == 1) begin
                apply_reset(1'b0);
                set_q(0, 1'b1, 10, 0);
                set_q(3, 1'b1, 13, 0);
                set_q(5, 1'b1, 15, 0);
            end else if (vecs[v].setup == 2) begin
                apply_reset(1'b1);
                set_q(0, 1'b1, 6, 4);
                set_q(1, 1'b1, 6, 8);
            end
            take_grant($sformatf("vec%0d", v), vecs[v].oq, vecs[v].len,
                       vecs[v].def);
            ack_grant();
            done_grant();
        end

        // Queue drained before its recheck: deficit dropped, scan moves on.
        apply_reset(1'b1);
        set_q(2, 1'b1, 3, 8);
        take_grant("t3_g1", 2, 3, 5);
        ack_grant();
        set_q(2, 1'b0, 3, 8);
        set_q(3, 1'b1, 2, 4);
        done_grant();
        take_grant("t3_g2", 3, 2, 2);
        chk("t3_def2", def_of(2), 0);
        ack_grant();
        done_grant();

        // Port not ready keeps credit; then a mode switch clears it.
        apply_reset(1'b1);
        set_q(1, 1'b1, 3, 10);
        take_grant("t4_g1", 1, 3, 7);
        ack_grant();
        out_rdy[1] = 1'b0;
        done_grant();
        repeat (20) step();
        chk("t4_idle", int'(grant_vld), 0);
        chk("t4_kept", def_of(1), 7);
        out_rdy[1] = 1'b1;
        take_grant("t4_g2", 1, 3, 14);
        ack_grant();
        drr_mode = 1'b0;
        done_grant();
        take_grant("t4_rr", 1, 3, -1);
        chk("t4_clr", def_of(1), 0);
        ack_grant();
        done_grant();

        // Grant held while ack is low; stray done pulses ignored.
        apply_reset(1'b0);
        set_q(4, 1'b1, 9, 0);
        take_grant("t5_g", 4, 9, -1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) head_len[4*PW +: PW] = 8'd20;
            pkt_done = (i % 3 == 0);
            step();
            pkt_done = 1'b0;
            chk($sformatf("t5_vld%0d", i), int'(grant_vld), 1);
            chk($sformatf("t5_oq%0d", i), int'(grant_oq), 4);
            chk($sformatf("t5_len%0d", i), int'(grant_len), 9);
        end
        ack_grant();
        done_grant();
        take_grant("t5_g2", 4, 20, -1);
        ack_grant();
        done_grant();

        // Reset during BUSY, then restart in RR and switch back to DRR.
        apply_reset(1'b1);
        set_q(0, 1'b1, 3, 8);
        set_q(2, 1'b1, 3, 8);
        take_grant("t6_g1", 0, 3, 5);
        ack_grant();
        done_grant();
        take_grant("t6_g2", 0, 3, 2);
        ack_grant();
        done_grant();
        take_grant("t6_g3", 2, 3, 5);
        ack_grant();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_vld", int'(grant_vld), 0);
        chk("t6_rst_oq", int'(grant_oq), 0);
        chk("t6_rst_len", int'(grant_len), 0);
        chk("t6_rst_def", def_of(2), 0);
        drr_mode = 1'b0;
        step();
        step();
        reset = 1'b1;
        take_grant("t6_rr0", 0, 3, -1);
        ack_grant();
        drr_mode = 1'b1;
        done_grant();
        take_grant("t6_drr", 2, 3, 5);
        ack_grant();
        done_grant();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
